// File: rtl/demux_rr_distributor_if.sv
// demux_rr_distributor_if
// Bundles the upstream and downstream handshake/data signals of the
// round-robin demultiplexer.
//   in_data   upstream payload            (upstream -> block)
//   in_valid  upstream offers in_data     (upstream -> block)
//   in_ready  block accepts in_data       (block -> upstream)
//   out_data  held payload, all channels  (block -> downstream)
//   out_valid one-hot channel offer       (block -> downstream)
//   out_ready per-channel accept          (downstream -> block)
// Modports: slave = the distributor, master = the environment driving it.
interface demux_rr_distributor_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/demux_rr_distributor.sv
// demux_rr_distributor
// Single-entry holding register that forwards each accepted upstream word to
// one of eight downstream channels, chosen round-robin over the enabled
// channels (mode=0) or fixed by fix_sel (mode=1).
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   bus       handshake/data bundle (slave modport)
//   mode      0 = round-robin, 1 = fixed channel
//   fix_sel   fixed target channel when mode=1
//   en_mask   per-channel eligibility
//   sel       channel index of the held payload
//   busy      high while a payload is held
//   xfer_cnt  completed downstream transfers, wraps at 16 bits
module demux_rr_distributor #(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  demux_rr_distributor_if.slave       bus,
  input  logic                        mode,
  input  logic [2:0]                  fix_sel,
  input  logic [7:0]                  en_mask,
  output logic [2:0]                  sel,
  output logic                        busy,
  output logic [15:0]                 xfer_cnt
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       last_q, last_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [2:0] last_eff;
  logic [2:0] rr_target;
  logic       rr_found;
  logic [2:0] target;
  logic       target_exists;
  logic       xfer;
  logic       in_hs;
  logic       in_ready_c;

  // A transfer can only happen out of HOLD; bits other than sel are ignored.
  assign xfer = (state_q == HOLD) && bus.out_ready[sel_q];

  // While holding, the next selection is computed as if the held word had
  // already gone, so a same-cycle refill continues the rotation past sel.
  assign last_eff = (state_q == HOLD) ? sel_q : last_q;

  // Round-robin search: walk offsets from 8 down to 1 so the smallest offset
  // from last_eff that hits an enabled channel wins. Offset 8 is last itself.
  always_comb begin
    logic [2:0] idx;
    rr_target = 3'd0;
    rr_found  = 1'b0;
    idx       = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = last_eff + 3'(k);
      if (en_mask[idx]) begin
        rr_target = idx;
        rr_found  = 1'b1;
      end
    end
  end

  always_comb begin
    if (mode) begin
      target        = fix_sel;
      target_exists = en_mask[fix_sel];
    end else begin
      target        = rr_target;
      target_exists = rr_found;
    end
  end

  // In HOLD, a new word is accepted only when the held one leaves this cycle.
  assign in_ready_c = (state_q == IDLE) ? target_exists : (xfer && target_exists);
  assign in_hs      = bus.in_valid && in_ready_c;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      last_d  = sel_q;
      cnt_d   = cnt_q + 16'd1;
      state_d = IDLE;
    end
    if (in_hs) begin
      data_d  = bus.in_data;
      sel_d   = target;
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= 3'd0;
      last_q  <= 3'd7;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == HOLD) ? (8'd1 << sel_q) : 8'h00;
  assign sel           = sel_q;
  assign busy          = (state_q == HOLD);
  assign xfer_cnt      = cnt_q;

endmodule

// File: tb/tb_demux_rr_distributor.sv
module tb_demux_rr_distributor;

  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  fix_sel = 3'd0;
  logic [7:0]  en_mask = 8'hFF;
  logic [2:0]  sel;
  logic        busy;
  logic [15:0] xfer_cnt;

  int errors = 0;
  int checks = 0;

  demux_rr_distributor_if #(.WIDTH(WIDTH)) bus ();

  demux_rr_distributor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mode     (mode),
    .fix_sel  (fix_sel),
    .en_mask  (en_mask),
    .sel      (sel),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge; sample/drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_sel_a [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int exp_sel_b [6]  = '{2, 5, 7, 2, 5, 7};

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 8'hFF;
    #12;
    // Reset state while rst_n is still low
    chk("rst_out_valid", 32'(bus.out_valid), 32'h00);
    chk("rst_out_data", 32'(bus.out_data), 32'h00);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Round-robin over all channels, sustained one per cycle
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 8'(8'h10 + i);
      tick();
      chk($sformatf("rr_all_sel[%0d]", i), 32'(sel), 32'(exp_sel_a[i]));
      chk($sformatf("rr_all_data[%0d]", i), 32'(bus.out_data), 32'(8'h10 + i));
      chk($sformatf("rr_all_valid[%0d]", i), 32'(bus.out_valid), 32'(8'd1 << exp_sel_a[i]));
      $display("rr_all step %0d sel=%0d data=%0h", i, sel, bus.out_data);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rr_all_cnt", 32'(xfer_cnt), 32'd10);
    chk("rr_all_idle", 32'(busy), 32'd0);

    // Sparse mask 1010_0100, rotation continues after channel 1
    en_mask = 8'b1010_0100;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.in_data = 8'(8'h40 + i);
      tick();
      chk($sformatf("rr_mask_sel[%0d]", i), 32'(sel), 32'(exp_sel_b[i]));
      $display("rr_mask step %0d sel=%0d", i, sel);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rr_mask_cnt", 32'(xfer_cnt), 32'd16);

    // Fixed channel 3 with backpressure on channel 3 only
    en_mask = 8'hFF;
    mode = 1'b1;
    fix_sel = 3'd3;
    bus.out_ready = 8'hF7;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAB;
    tick();
    bus.in_data = 8'hCD;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        en_mask = 8'h01;
        mode = 1'b0;
      end
      #1;
      chk($sformatf("fix_valid[%0d]", i), 32'(bus.out_valid), 32'h08);
      chk($sformatf("fix_in_ready[%0d]", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("fix_data[%0d]", i), 32'(bus.out_data), 32'hAB);
      chk($sformatf("fix_sel[%0d]", i), 32'(sel), 32'd3);
      $display("fix hold cycle %0d out_valid=%0h data=%0h", i, bus.out_valid, bus.out_data);
      tick();
    end
    en_mask = 8'hFF;
    mode = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 8'hFF;
    #1;
    chk("fix_release_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    chk("fix_release_cnt", 32'(xfer_cnt), 32'd17);
    chk("fix_release_idle", 32'(busy), 32'd0);

    // No eligible target
    mode = 1'b0;
    en_mask = 8'h00;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h77;
    #1;
    chk("nomask_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("nomask_busy", 32'(busy), 32'd0);
    chk("nomask_cnt", 32'(xfer_cnt), 32'd17);
    mode = 1'b1;
    fix_sel = 3'd3;
    en_mask = 8'hF7;
    #1;
    chk("fix_disabled_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    chk("fix_disabled_busy", 32'(busy), 32'd0);
    $display("no-target cases done busy=%0d", busy);

    // Reset mid-HOLD: last was 3, so without reset the next target would be 4
    mode = 1'b0;
    en_mask = 8'hFF;
    bus.out_ready = 8'h00;
    bus.in_data = 8'h5A;
    tick();
    bus.in_valid = 1'b0;
    chk("prerst_sel", 32'(sel), 32'd4);
    chk("prerst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'h00);
    chk("midrst_cnt", 32'(xfer_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 8'hFF;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h66;
    tick();
    chk("postrst_sel", 32'(sel), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("postrst_cnt", 32'(xfer_cnt), 32'd1);
    $display("reset mid-hold done xfer_cnt=%0d", xfer_cnt);

    // Counter wrap: 65535 transfers, then one more
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = 8'(i);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_pre_cnt", 32'(xfer_cnt), 32'hFFFF);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("wrap_cnt", 32'(xfer_cnt), 32'h0000);
    $display("counter wrap done xfer_cnt=%0h", xfer_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_rr_distributor.md
DEMUX_RR_DISTRIBUTOR -- requirements
Module: demux_rr_distributor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data path width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 selects round-robin, 1 selects fixed channel.
REQ-008 The block SHALL have port fix_sel, input, 3 bits: the target channel when mode=1.
REQ-009 The block SHALL have port en_mask, input, 8 bits: bit k=1 makes channel k eligible.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the held payload, shared by all channels.
REQ-011 The block SHALL have port out_valid, output, 8 bits: one-hot, bit k marks payload offered to channel k.
REQ-012 The block SHALL have port out_ready, input, 8 bits: bit k means channel k accepts the payload.
REQ-013 The block SHALL have port sel, output, 3 bits: the channel index of the held payload.
REQ-014 The block SHALL have port busy, output, 1 bit: high in HOLD.
REQ-015 The block SHALL have port xfer_cnt, output, 16 bits: count of completed downstream transfers.

Function
REQ-016 The block SHALL implement two states: IDLE (holding register empty) and HOLD (holding register full).
REQ-017 Target selection SHALL be as follows. With mode=0, target = first index k with en_mask[k]=1, searching last+1, last+2, ... modulo 8. With mode=1, target = fix_sel, eligible only if en_mask[fix_sel]=1.
REQ-018 The block SHALL define "target exists" as: mode=0 and en_mask!=0, or mode=1 and en_mask[fix_sel]=1.
REQ-019 In IDLE, in_ready SHALL equal "target exists".
REQ-020 In HOLD, in_ready SHALL equal out_ready[sel] AND "target exists", computed with last updated to sel.
REQ-021 An input handshake (in_valid & in_ready) SHALL capture in_data into out_data, load sel with the target, and leave the block in or move it to HOLD.
REQ-022 In HOLD, out_valid SHALL be one-hot at bit sel; in IDLE, out_valid SHALL be 8'h00.
REQ-023 A downstream transfer SHALL be out_valid[sel] & out_ready[sel]; on it, last<=sel, xfer_cnt increments, and the state goes to IDLE unless a simultaneous input handshake occurs.
REQ-024 On a simultaneous transfer and input handshake, the state SHALL stay in HOLD with the new payload and target, giving one transfer per cycle sustained.
REQ-025 out_data and sel SHALL stay stable while out_valid is high and no transfer has occurred.
REQ-026 en_mask, mode and fix_sel changes during HOLD SHALL NOT alter sel or out_data; they affect only the next selection.
REQ-027 out_ready bits other than sel SHALL be ignored.
REQ-028 xfer_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 Round-robin SHALL wrap from channel 7 to channel 0 and skip channels whose en_mask bit is 0.

Reset
REQ-030 While rst_n=0, the block SHALL be held asynchronously in IDLE with out_valid=0, out_data=0, sel=0, busy=0, xfer_cnt=0 and last=7 (first round-robin target is the lowest enabled channel).
REQ-031 Reset asserted during HOLD SHALL discard the held payload with no transfer counted.
REQ-032 In the first cycle after rst_n deasserts, in_ready SHALL be valid per REQ-019.

Verification
REQ-033 Bench scenario: mode=0, en_mask=8'hFF, all out_ready=1, in_valid=1 for 10 cycles -> sel sequence 0,1,...,7,0,1 on consecutive cycles; xfer_cnt=10.
REQ-034 Bench scenario: mode=0, en_mask=8'b1010_0100 -> targets 2,5,7,2,... only.
REQ-035 Bench scenario: mode=1, fix_sel=3, out_ready[3]=0 for 4 cycles -> out_valid=8'h08 held, in_ready=0, out_data stable; on out_ready[3]=1 one transfer completes.
REQ-036 Bench scenario: en_mask=0 -> in_ready=0 and no capture; mode=1 with en_mask[fix_sel]=0 -> in_ready=0.
REQ-037 Bench scenario: rst_n pulsed low mid-HOLD -> out_valid=0 immediately, xfer_cnt=0, next round-robin target is the lowest enabled channel.
REQ-038 Bench scenario: xfer_cnt preloaded by 65535 transfers, then one more transfer -> xfer_cnt=0.
